// File: rtl/idu_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : idu_hazard_ctrl_pkg
// Purpose  : Shared types and constants for the decode-stage hazard controller:
//            sequencing FSM state encoding, serialising-instruction kind codes
//            and the canonical NOP encoding used for pipeline bubbles.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package idu_hazard_ctrl_pkg;

  // Sequencing FSM states. RUN is the only state in which decode flows freely.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_INV   = 2'd2,
    ST_REDIR = 2'd3
  } state_e;

  // Kind of serialising instruction captured when leaving RUN; selects the
  // redirect target and whether the I-cache must be invalidated first.
  typedef enum logic [1:0] {
    SER_FENCEI = 2'd0,
    SER_ECALL  = 2'd1,
    SER_MRET   = 2'd2
  } ser_kind_e;

  // addi x0, x0, 0 - what EXU sees while IDU is held.
  localparam logic [31:0] NOP_INS = 32'h0000_0013;

endpackage : idu_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/idu_hazard_ctrl_inv_timer.sv
`default_nettype none
// ============================================================================
// Module   : idu_hazard_ctrl_inv_timer
// Purpose  : Clear/enable up-counter bounding the wait for the I-cache
//            invalidate acknowledge. o_tc is high while the count equals
//            INV_TIMEOUT-1, i.e. during the INV_TIMEOUT-th enabled cycle.
// Ports    : i_clk  - core clock
//            i_rst  - synchronous active-high reset
//            i_clr  - synchronous clear (wins over i_en)
//            i_en   - count enable
//            o_tc   - terminal count reached
// Revision : 1.0 - initial release
// ============================================================================
module idu_hazard_ctrl_inv_timer
  import idu_hazard_ctrl_pkg::*;
#(
  parameter int INV_TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int             CNT_W  = (INV_TIMEOUT > 1) ? $clog2(INV_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] c_TC_VAL = CNT_W'(INV_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + c_ONE;
    end
  end

  assign o_tc = (r_cnt == c_TC_VAL);

endmodule : idu_hazard_ctrl_inv_timer
`default_nettype wire

// File: rtl/idu_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : idu_hazard_ctrl
// Purpose  : Decode-stage sequencing controller. Resolves load-use hazards,
//            taken-branch redirects and serialising instructions (fence.i,
//            ecall, mret), and runs the I-cache invalidate handshake.
// Ports    : i_clk, i_rst            - clock, synchronous active-high reset
//            i_idu_*                  - instruction currently held in IDU
//            i_exu_*, i_lsu_valid,
//            i_wbu_valid              - occupancy of the back-end stages
//            i_bru_jump, i_bru_pc     - resolved taken branch and its target
//            i_mtvec, i_mepc          - trap vector / trap return PC
//            i_inv_ack                - I-cache invalidate done pulse
//            o_idu_hold               - hold IDU, bubble into EXU
//            o_flush, o_redirect,
//            o_redirect_pc            - front-end flush and PC redirect
//            o_inv_req, o_inv_err     - invalidate request / timeout pulse
//            o_busy                   - sequencer not in RUN
// Revision : 1.0 - initial release
// ============================================================================
module idu_hazard_ctrl
  import idu_hazard_ctrl_pkg::*;
#(
  parameter int CPU_WIDTH   = 64,
  parameter int REG_ADDRW   = 5,
  parameter int INV_TIMEOUT = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_idu_valid,
  input  logic [REG_ADDRW-1:0] i_idu_rs1id,
  input  logic [REG_ADDRW-1:0] i_idu_rs2id,
  input  logic                 i_idu_fencei,
  input  logic                 i_idu_ecall,
  input  logic                 i_idu_mret,
  input  logic [CPU_WIDTH-1:0] i_idu_pc,
  input  logic                 i_exu_valid,
  input  logic                 i_exu_lden,
  input  logic [REG_ADDRW-1:0] i_exu_rdid,
  input  logic                 i_lsu_valid,
  input  logic                 i_wbu_valid,
  input  logic                 i_bru_jump,
  input  logic [CPU_WIDTH-1:0] i_bru_pc,
  input  logic [CPU_WIDTH-1:0] i_mtvec,
  input  logic [CPU_WIDTH-1:0] i_mepc,
  input  logic                 i_inv_ack,
  output logic                 o_idu_hold,
  output logic                 o_flush,
  output logic                 o_redirect,
  output logic [CPU_WIDTH-1:0] o_redirect_pc,
  output logic                 o_inv_req,
  output logic                 o_inv_err,
  output logic                 o_busy
);

  localparam logic [CPU_WIDTH-1:0] c_INSN_BYTES = CPU_WIDTH'(4);

  state_e               r_state;
  ser_kind_e            r_kind;
  logic [CPU_WIDTH-1:0] r_pc;

  logic      w_ser;
  ser_kind_e w_ser_kind;
  logic      w_load_use;
  logic      w_backend_empty;
  logic      w_inv_tc;
  logic      w_inv_done;
  logic      w_tmr_clr;
  logic      w_tmr_en;

  // --------------------------------------------------------------------------
  // Hazard detection (pure combinational on current inputs)
  // --------------------------------------------------------------------------
  assign w_ser = i_idu_valid & (i_idu_fencei | i_idu_ecall | i_idu_mret);

  // x0 is never a real dependency, so a load targeting it cannot stall decode.
  assign w_load_use = i_idu_valid & i_exu_valid & i_exu_lden
                    & (i_exu_rdid != '0)
                    & ((i_exu_rdid == i_idu_rs1id) | (i_exu_rdid == i_idu_rs2id));

  assign w_backend_empty = ~i_exu_valid & ~i_lsu_valid & ~i_wbu_valid;

  always_comb begin
    w_ser_kind = SER_FENCEI;
    if (i_idu_fencei) begin
      w_ser_kind = SER_FENCEI;
    end else if (i_idu_ecall) begin
      w_ser_kind = SER_ECALL;
    end else if (i_idu_mret) begin
      w_ser_kind = SER_MRET;
    end
  end

  // --------------------------------------------------------------------------
  // Invalidate wait timer
  // --------------------------------------------------------------------------
  // An ack on the terminal-count cycle is treated as success, not a timeout.
  assign w_inv_done = (r_state == ST_INV) & (i_inv_ack | w_inv_tc);
  // Clearing on the exit cycle keeps the next fence.i on a full timeout budget.
  assign w_tmr_clr  = (r_state != ST_INV) | w_inv_done;
  assign w_tmr_en   = (r_state == ST_INV);

  idu_hazard_ctrl_inv_timer #(
    .INV_TIMEOUT (INV_TIMEOUT)
  ) u_inv_timer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_tmr_clr),
    .i_en  (w_tmr_en),
    .o_tc  (w_inv_tc)
  );

  // --------------------------------------------------------------------------
  // Sequencing FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_RUN;
      r_kind  <= SER_FENCEI;
      r_pc    <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          // A taken branch makes the decoded instruction wrong-path, and a
          // load-use stall must clear before the instruction may serialise.
          if (!i_bru_jump && !w_load_use && w_ser) begin
            r_state <= ST_DRAIN;
            r_kind  <= w_ser_kind;
            r_pc    <= i_idu_pc;
          end
        end
        ST_DRAIN: begin
          // Older instructions are already resolved, so i_bru_jump cannot
          // occur legitimately here and is not looked at.
          if (w_backend_empty) begin
            r_state <= (r_kind == SER_FENCEI) ? ST_INV : ST_REDIR;
          end
        end
        ST_INV: begin
          if (w_inv_done) begin
            r_state <= ST_REDIR;
          end
        end
        ST_REDIR: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode: RUN outputs follow the inputs with zero latency, the other
  // states decode from the registered state. Everything is forced low while
  // reset is asserted so no flush or redirect escapes during reset.
  // --------------------------------------------------------------------------
  always_comb begin
    o_idu_hold    = 1'b0;
    o_flush       = 1'b0;
    o_redirect    = 1'b0;
    o_redirect_pc = '0;
    o_inv_req     = 1'b0;
    o_inv_err     = 1'b0;
    o_busy        = 1'b0;
    if (!i_rst) begin
      o_busy = (r_state != ST_RUN);
      case (r_state)
        ST_RUN: begin
          if (i_bru_jump) begin
            o_flush       = 1'b1;
            o_redirect    = 1'b1;
            o_redirect_pc = i_bru_pc;
          end else if (w_load_use || w_ser) begin
            o_idu_hold = 1'b1;
          end
        end
        ST_DRAIN: begin
          o_idu_hold = 1'b1;
        end
        ST_INV: begin
          o_idu_hold = 1'b1;
          o_inv_req  = 1'b1;
          o_inv_err  = w_inv_tc & ~i_inv_ack;
        end
        ST_REDIR: begin
          o_flush    = 1'b1;
          o_redirect = 1'b1;
          case (r_kind)
            SER_FENCEI: o_redirect_pc = r_pc + c_INSN_BYTES;
            SER_ECALL:  o_redirect_pc = i_mtvec;
            SER_MRET:   o_redirect_pc = i_mepc;
            default:    o_redirect_pc = '0;
          endcase
        end
        default: begin
          o_busy = 1'b1;
        end
      endcase
    end
  end

endmodule : idu_hazard_ctrl
`default_nettype wire

// File: tb/tb_idu_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_idu_hazard_ctrl
// Purpose  : Self-checking bench for idu_hazard_ctrl: directed scenarios
//            followed by randomized traffic, all outputs compared each cycle
//            against a transaction-level model of the sequencing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idu_hazard_ctrl;

  localparam int CW = 64;
  localparam int RW = 5;
  localparam int T  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          idu_valid, fencei, ecall, mret;
  logic [RW-1:0] rs1, rs2, exu_rdid;
  logic [CW-1:0] idu_pc, bru_pc, mtvec, mepc;
  logic          exu_valid, exu_lden, lsu_valid, wbu_valid, bru_jump, inv_ack;
  logic          hold, flush, redir, inv_req, inv_err, busy;
  logic [CW-1:0] redir_pc;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: the serialising op in progress and where it is in its life.
  int          m_op;        // 0 none, 1 fence.i, 2 ecall, 3 mret
  logic [CW-1:0] m_pc;
  bit          m_draining;
  int          m_inv_age;   // -1 when not waiting for the invalidate
  bit          m_redir;

  always #5 clk = ~clk;

  idu_hazard_ctrl #(.CPU_WIDTH(CW), .REG_ADDRW(RW), .INV_TIMEOUT(T)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_idu_valid(idu_valid), .i_idu_rs1id(rs1), .i_idu_rs2id(rs2),
    .i_idu_fencei(fencei), .i_idu_ecall(ecall), .i_idu_mret(mret),
    .i_idu_pc(idu_pc),
    .i_exu_valid(exu_valid), .i_exu_lden(exu_lden), .i_exu_rdid(exu_rdid),
    .i_lsu_valid(lsu_valid), .i_wbu_valid(wbu_valid),
    .i_bru_jump(bru_jump), .i_bru_pc(bru_pc),
    .i_mtvec(mtvec), .i_mepc(mepc), .i_inv_ack(inv_ack),
    .o_idu_hold(hold), .o_flush(flush), .o_redirect(redir),
    .o_redirect_pc(redir_pc), .o_inv_req(inv_req), .o_inv_err(inv_err),
    .o_busy(busy)
  );

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_op = 0; m_pc = '0; m_draining = 0; m_inv_age = -1; m_redir = 0;
  endtask

  // One clock: called just after a negedge with inputs set; checks every
  // output against the model, advances the model at posedge, returns at the
  // next negedge.
  task automatic cycle();
    logic e_hold, e_flush, e_redir, e_req, e_err, e_busy;
    logic [CW-1:0] e_pc;
    bit lu, empty;
    int sop;
    #1;
    lu    = idu_valid && exu_valid && exu_lden && (exu_rdid != 0) &&
            (exu_rdid == rs1 || exu_rdid == rs2);
    sop   = !idu_valid ? 0 : fencei ? 1 : ecall ? 2 : mret ? 3 : 0;
    empty = !exu_valid && !lsu_valid && !wbu_valid;
    e_hold = 0; e_flush = 0; e_redir = 0; e_req = 0; e_err = 0; e_busy = 0; e_pc = '0;
    if (!rst) begin
      if (m_redir) begin
        e_flush = 1; e_redir = 1; e_busy = 1;
        e_pc = (m_op == 1) ? m_pc + 64'd4 : (m_op == 2) ? mtvec : mepc;
      end else if (m_inv_age >= 0) begin
        e_hold = 1; e_req = 1; e_busy = 1;
        e_err  = !inv_ack && (m_inv_age == T - 1);
      end else if (m_draining) begin
        e_hold = 1; e_busy = 1;
      end else if (bru_jump) begin
        e_flush = 1; e_redir = 1; e_pc = bru_pc;
      end else if (lu || sop != 0) begin
        e_hold = 1;
      end
    end
    chk("hold",     {63'd0, hold},    {63'd0, e_hold});
    chk("flush",    {63'd0, flush},   {63'd0, e_flush});
    chk("redirect", {63'd0, redir},   {63'd0, e_redir});
    chk("redir_pc", redir_pc,         e_pc);
    chk("inv_req",  {63'd0, inv_req}, {63'd0, e_req});
    chk("inv_err",  {63'd0, inv_err}, {63'd0, e_err});
    chk("busy",     {63'd0, busy},    {63'd0, e_busy});
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (m_redir) begin
      m_redir = 0; m_op = 0;
    end else if (m_inv_age >= 0) begin
      if (inv_ack || m_inv_age == T - 1) begin
        m_inv_age = -1; m_redir = 1;
      end else begin
        m_inv_age++;
      end
    end else if (m_draining) begin
      if (empty) begin
        m_draining = 0;
        if (m_op == 1) m_inv_age = 0;
        else           m_redir = 1;
      end
    end else if (!bru_jump && !lu && sop != 0) begin
      m_op = sop; m_pc = idu_pc; m_draining = 1;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    idu_valid = 0; fencei = 0; ecall = 0; mret = 0; rs1 = '0; rs2 = '0;
    idu_pc = '0; exu_valid = 0; exu_lden = 0; exu_rdid = '0; lsu_valid = 0;
    wbu_valid = 0; bru_jump = 0; bru_pc = '0; inv_ack = 0;
  endtask

  // Issue a fence.i with an empty back end; returns on the first INV cycle.
  task automatic fencei_to_inv(input logic [CW-1:0] pc);
    idu_valid = 1; fencei = 1; idu_pc = pc;
    cycle();            // RUN -> DRAIN
    cycle();            // DRAIN -> INV
  endtask

  initial begin
    int inv_cycles;
    int err_at;
    idle_inputs();
    mtvec = 64'h8000_0400; mepc = 64'h8000_0200;
    rst = 1;
    model_reset();
    @(negedge clk);
    cycle(); cycle();
    rst = 0;

    // Reset state
    #1; chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_hold", {63'd0, hold}, 64'd0);
    cycle();

    // Load-use on rs2, then EXU advances, then rdid=0
    idu_valid = 1; rs1 = 5'd3; rs2 = 5'd5;
    exu_valid = 1; exu_lden = 1; exu_rdid = 5'd5;
    #1; chk("lu_hold", {63'd0, hold}, 64'd1);
    cycle();
    exu_valid = 0;
    #1; chk("lu_release", {63'd0, hold}, 64'd0);
    cycle();
    exu_valid = 1; exu_rdid = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    #1; chk("lu_x0", {63'd0, hold}, 64'd0);
    cycle();
    idle_inputs();

    // Branch beats ecall in decode; FSM stays in RUN
    bru_jump = 1; bru_pc = 64'h8000_0100; idu_valid = 1; ecall = 1;
    #1; chk("br_pc", redir_pc, 64'h8000_0100);
    chk("br_flush", {63'd0, flush}, 64'd1);
    cycle();
    idle_inputs();
    #1; chk("br_stay_run", {63'd0, busy}, 64'd0);
    cycle();

    // ecall with empty back end: DRAIN then REDIR to mtvec
    idu_valid = 1; ecall = 1; inv_ack = 1;   // stray ack in RUN is ignored
    cycle();
    inv_ack = 0;
    #1; chk("ec_drain_busy", {63'd0, busy}, 64'd1);
    cycle();
    #1; chk("ec_pc", redir_pc, 64'h8000_0400);
    chk("ec_redir", {63'd0, redir}, 64'd1);
    cycle();
    idle_inputs();
    #1; chk("ec_back_run", {63'd0, busy}, 64'd0);
    cycle();

    // fence.i with WBU busy for 2 drain cycles, ack on third INV cycle
    idu_valid = 1; fencei = 1; idu_pc = 64'h8000_0010;
    cycle();
    wbu_valid = 1; cycle(); cycle();
    wbu_valid = 0; cycle();
    inv_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      inv_ack = (i == 2);
      #1; if (inv_req) inv_cycles++;
      cycle();
    end
    inv_ack = 0;
    chk("fi_inv_cycles", 64'(inv_cycles), 64'd3);
    #1; chk("fi_pc", redir_pc, 64'h8000_0014);
    cycle();
    idle_inputs(); cycle();

    // Timeout without ack: err on the 4th INV cycle
    fencei_to_inv(64'h8000_0020);
    err_at = -1;
    for (int i = 0; i < T; i++) begin
      #1; if (inv_err) err_at = i;
      cycle();
    end
    chk("to_err_cycle", 64'(err_at), 64'(T - 1));
    #1; chk("to_pc", redir_pc, 64'h8000_0024);
    cycle();
    idle_inputs(); cycle();

    // Ack on the timeout cycle wins: no err
    fencei_to_inv(64'h8000_0030);
    for (int i = 0; i < T; i++) begin
      inv_ack = (i == T - 1);
      #1; chk("ack_at_to_noerr", {63'd0, inv_err}, 64'd0);
      cycle();
    end
    inv_ack = 0;
    cycle();
    idle_inputs(); cycle();

    // Reset during INV cycle 2, then a fresh fence.i gets the full timeout
    fencei_to_inv(64'h8000_0040);
    cycle();
    rst = 1; cycle();
    rst = 0; idle_inputs();
    #1; chk("rst_inv_req", {63'd0, inv_req}, 64'd0);
    chk("rst_no_redir", {63'd0, redir}, 64'd0);
    chk("rst_run", {63'd0, busy}, 64'd0);
    cycle();
    fencei_to_inv(64'h8000_0050);
    err_at = -1;
    for (int i = 0; i < T; i++) begin
      #1; if (inv_err) err_at = i;
      cycle();
    end
    chk("rst_full_timeout", 64'(err_at), 64'(T - 1));
    cycle();
    idle_inputs(); cycle();

    // pc+4 wraps; mret returns to mepc
    fencei_to_inv(64'hFFFF_FFFF_FFFF_FFFC);
    inv_ack = 1; cycle(); inv_ack = 0;
    #1; chk("wrap_pc", redir_pc, 64'd0);
    cycle();
    idle_inputs();
    idu_valid = 1; mret = 1; cycle(); cycle();
    #1; chk("mret_pc", redir_pc, 64'h8000_0200);
    cycle();
    idle_inputs(); cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      int s;
      rst       = ($urandom_range(0, 63) == 0);
      idu_valid = ($urandom_range(0, 3) != 0);
      s         = $urandom_range(0, 11);
      fencei    = (s == 0); ecall = (s == 1); mret = (s == 2);
      rs1       = RW'($urandom_range(0, 3));
      rs2       = RW'($urandom_range(0, 3));
      idu_pc    = {32'h8000_0000, $urandom} & ~64'd3;
      exu_valid = ($urandom_range(0, 2) == 0);
      exu_lden  = $urandom_range(0, 1) == 1;
      exu_rdid  = RW'($urandom_range(0, 3));
      lsu_valid = ($urandom_range(0, 2) == 0);
      wbu_valid = ($urandom_range(0, 2) == 0);
      bru_jump  = ($urandom_range(0, 7) == 0);
      bru_pc    = {32'h0, $urandom};
      mtvec     = {32'h8000_0000, $urandom};
      mepc      = {32'h8000_0000, $urandom};
      inv_ack   = ($urandom_range(0, 4) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_idu_hazard_ctrl
`default_nettype wire
